// File: rtl/mmio_uart_tx_if.sv
// Bundle of the MMIO words and serial line between the core and the UART transmitter.
// The master side is the core (drives the command word), the slave side is the transmitter.
`timescale 1ns/1ps

interface mmio_uart_tx_if;
   logic [31:0] mmioCommand;
   logic [31:0] mmioStatus;
   logic        txd;

   modport master (
      output mmioCommand,
      input  mmioStatus,
      input  txd
   );

   modport slave (
      input  mmioCommand,
      output mmioStatus,
      output txd
   );
endinterface

// File: rtl/mmio_uart_tx.sv
// Software-driven 8N1 serial transmitter.
// Software writes a byte plus a flipped toggle bit into the command word; the byte is queued in
// a small circular FIFO and shifted out LSB first. A registered status word reports queue state,
// an ack toggle that mirrors the last seen request, and a sticky overflow flag.
`timescale 1ns/1ps

module mmio_uart_tx #(
   parameter int BAUD_DIVISOR = 434,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clock,
   input  logic        reset,
   mmio_uart_tx_if.slave bus
);

   localparam int PtrWidth   = $clog2(FIFO_DEPTH);
   localparam int CountWidth = PtrWidth + 1;
   localparam logic [15:0] BaudReload = 16'(BAUD_DIVISOR - 1);
   localparam logic [CountWidth-1:0] FullCount = CountWidth'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } txState_t;

   txState_t state, stateNext;

   logic [7:0]  commandData;
   logic        sendToggle;
   logic        clearOverflow;
   logic        unusedCommandBits;

   logic [15:0] baudCount, baudNext;
   logic [2:0]  bitIndex, bitIndexNext;
   logic [7:0]  shiftReg, shiftNext;
   logic        txdReg, txdNext;
   logic        bitEnd;
   logic        pop;

   logic [7:0]            fifoMem [FIFO_DEPTH];
   logic [PtrWidth-1:0]   wrPtr, rdPtr;
   logic [CountWidth-1:0] count;
   logic                  fifoEmpty, fifoFull;

   logic        prevToggle;
   logic        ackToggle;
   logic        overflow;
   logic        req;
   logic        push;
   logic        busy;
   logic [31:0] statusReg;

   assign commandData       = bus.mmioCommand[7:0];
   assign sendToggle        = bus.mmioCommand[8];
   assign clearOverflow     = bus.mmioCommand[9];
   assign unusedCommandBits = ^bus.mmioCommand[31:10];

   assign req       = (sendToggle != prevToggle);
   assign fifoEmpty = (count == '0);
   assign fifoFull  = (count == FullCount);
   assign bitEnd    = (baudCount == 16'd0);
   assign push      = req && (!fifoFull || pop);
   assign busy      = (state != IDLE) || !fifoEmpty;

   assign bus.txd        = txdReg;
   assign bus.mmioStatus = statusReg;

   // Frame sequencer: decides the next bit state, reloads the baud counter and pops the FIFO
   // only from IDLE or at the very end of the stop bit so frames can run back to back.
   always_comb begin
      stateNext    = state;
      baudNext     = bitEnd ? BaudReload : (baudCount - 16'd1);
      bitIndexNext = bitIndex;
      shiftNext    = shiftReg;
      pop          = 1'b0;
      case (state)
         IDLE: begin
            baudNext = BaudReload;
            if (!fifoEmpty) begin
               pop       = 1'b1;
               shiftNext = fifoMem[rdPtr];
               stateNext = START;
            end
         end
         START: begin
            if (bitEnd) begin
               stateNext    = DATA;
               bitIndexNext = 3'd0;
            end
         end
         DATA: begin
            if (bitEnd) begin
               shiftNext = {1'b0, shiftReg[7:1]};
               if (bitIndex == 3'd7) begin
                  stateNext = STOP;
               end else begin
                  bitIndexNext = bitIndex + 3'd1;
               end
            end
         end
         STOP: begin
            if (bitEnd) begin
               if (!fifoEmpty) begin
                  pop       = 1'b1;
                  shiftNext = fifoMem[rdPtr];
                  stateNext = START;
               end else begin
                  stateNext = IDLE;
               end
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase

      case (stateNext)
         START:   txdNext = 1'b0;
         DATA:    txdNext = shiftNext[0];
         default: txdNext = 1'b1;
      endcase
   end

   // Sequencer registers; txd is taken from its own flop so the line never glitches,
   // and a reset mid-frame drives the line high immediately.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         baudCount <= BaudReload;
         bitIndex  <= 3'd0;
         shiftReg  <= 8'd0;
         txdReg    <= 1'b1;
      end else begin
         state     <= stateNext;
         baudCount <= baudNext;
         bitIndex  <= bitIndexNext;
         shiftReg  <= shiftNext;
         txdReg    <= txdNext;
      end
   end

   // FIFO bookkeeping; a push that lands in the same cycle as a pop takes the freed slot.
   always_ff @(posedge clock) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + PtrWidth'(1);
         end
         if (pop) begin
            rdPtr <= rdPtr + PtrWidth'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CountWidth'(1);
            2'b01:   count <= count - CountWidth'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage; only accepted pushes write, so a dropped byte never touches stored entries.
   always_ff @(posedge clock) begin
      if (push) begin
         fifoMem[wrPtr] <= commandData;
      end
   end

   // Request edge detection, ack mirroring and the sticky overflow flag (a set beats a clear).
   // Reset samples the current toggle so a toggle already set during reset never sends.
   always_ff @(posedge clock) begin
      if (reset) begin
         prevToggle <= sendToggle;
         ackToggle  <= sendToggle;
         overflow   <= 1'b0;
      end else begin
         prevToggle <= sendToggle;
         if (req) begin
            ackToggle <= sendToggle;
         end
         if (req && !push) begin
            overflow <= 1'b1;
         end else if (clearOverflow) begin
            overflow <= 1'b0;
         end
      end
   end

   // Registered status word for software polling, one cycle behind the state it reports.
   always_ff @(posedge clock) begin
      if (reset) begin
         statusReg <= {22'd0, 1'b0, sendToggle, 5'd0, 1'b1, 1'b0, 1'b0};
      end else begin
         statusReg <= {22'd0, overflow, ackToggle, 5'(count), fifoEmpty, fifoFull, busy};
      end
   end

endmodule
